// File: rtl/gpio_apb_arb_pkg.sv
// gpio_apb_arb_pkg: shared state encoding and width helpers for the GPIO APB arbiter.
package gpio_apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_e;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int strb_w(int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/gpio_apb_arb_rr.sv
// gpio_apb_arb_rr: combinational round-robin picker, lowest offset from ptr among unmasked requests wins.
module gpio_apb_arb_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] win
);
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N] && !mask[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        win   = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin arbiter sharing one APB slave port among NUM_REQ masters.
// Define GPIO_APB_ARB_TIMEOUT_EN to add an access-phase timeout that completes with an error.
module gpio_apb_arbiter
  import gpio_apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   s_psel,
  input  logic [NUM_REQ-1:0]                   s_penable,
  input  logic [NUM_REQ-1:0]                   s_pwrite,
  input  logic [NUM_REQ*ADDR_W-1:0]            s_paddr,
  input  logic [NUM_REQ*DATA_W-1:0]            s_pwdata,
  input  logic [NUM_REQ*strb_w(DATA_W)-1:0]    s_pstrb,
  output logic [NUM_REQ-1:0]                   s_pready,
  output logic [DATA_W-1:0]                    s_prdata,
  output logic [NUM_REQ-1:0]                   s_pslverr,
  output logic                                 m_psel,
  output logic                                 m_penable,
  output logic                                 m_pwrite,
  output logic [ADDR_W-1:0]                    m_paddr,
  output logic [DATA_W-1:0]                    m_pwdata,
  output logic [strb_w(DATA_W)-1:0]            m_pstrb,
  input  logic [DATA_W-1:0]                    m_prdata,
  input  logic                                 m_pready,
  input  logic                                 m_pslverr,
  output logic [idx_w(NUM_REQ)-1:0]            grant_id,
  output logic                                 busy
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int SW = strb_w(DATA_W);
  arb_state_e state, state_nx;
  logic [IW-1:0] rr_ptr, nxt_ptr, win;
  logic [NUM_REQ-1:0] gnt_oh, mask;
  logic valid, done, timeout, load;
  // Arbitration only progresses on psel; penable is carried by the protocol but not needed here.
  logic unused_penable;
  assign unused_penable = ^s_penable;
  assign gnt_oh  = NUM_REQ'(1) << grant_id;
  assign nxt_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  assign done    = (state == ACCESS) && (m_pready || timeout);
  assign mask    = done ? gnt_oh : '0;
  gpio_apb_arb_rr #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req   (s_psel),
    .mask  (mask),
    .ptr   (done ? nxt_ptr : rr_ptr),
    .valid (valid),
    .win   (win)
  );
  always_comb begin
    load     = valid && (state == IDLE || done);
    state_nx = load ? SETUP : (state == SETUP) ? ACCESS : done ? IDLE : state;
  end
  assign m_psel    = state != IDLE;
  assign m_penable = state == ACCESS;
  assign busy      = m_psel;
  assign s_pready  = done ? gnt_oh : '0;
  assign s_pslverr = (done && (!m_pready || m_pslverr)) ? gnt_oh : '0;
  assign s_prdata  = (state == ACCESS && m_pready) ? m_prdata : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      m_pwrite <= 1'b0;
      m_paddr  <= '0;
      m_pwdata <= '0;
      m_pstrb  <= '0;
    end else begin
      state <= state_nx;
      if (done) rr_ptr <= nxt_ptr;
      if (load) begin
        grant_id <= win;
        m_pwrite <= s_pwrite[win];
        m_paddr  <= s_paddr[int'(win)*ADDR_W +: ADDR_W];
        m_pwdata <= s_pwdata[int'(win)*DATA_W +: DATA_W];
        m_pstrb  <= s_pstrb[int'(win)*SW +: SW];
      end
    end
  end
`ifdef GPIO_APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt;
  // Held at zero outside ACCESS, so every entry to ACCESS starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_n || state != ACCESS) to_cnt <= '0;
    else if (!m_pready) to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = (state == ACCESS) && !m_pready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
endmodule
